// File: rtl/accu_pkg.sv
// Shared encodings for the one-accumulator: receiver state codes and the
// transmit FSM states used by accu_stim_tx.
package accu_pkg;

    // Receiver state codes, shared with the accumulator itself.
    localparam logic [2:0] START   = 3'd0;
    localparam logic [2:0] FIRST1  = 3'd1;
    localparam logic [2:0] SECOND1 = 3'd2;
    localparam logic [2:0] THIRD1  = 3'd3;
    localparam logic [2:0] FOURTH1 = 3'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        GAP    = 2'd3
    } tx_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/accu_ref_model.sv
// Behavioural twin of the accumulator's receiver: advances on each strobe
// rising edge and predicts its out pin, counting entries into FOURTH1.
module accu_ref_model (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_bit,
    input  logic       strobe_rise,
    output logic [2:0] state,
    output logic       expected_out,
    output logic [7:0] run_count
);
    import accu_pkg::*;

    logic [2:0] state_nxt;

    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        if (strobe_rise) begin
            if (data_bit)
                state_nxt = (state == FOURTH1) ? FIRST1 : state + 3'd1;
            else if (state == FOURTH1)
                state_nxt = START;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= START;
            expected_out <= 1'b0;
            run_count    <= 8'd0;
        end else begin
            state        <= state_nxt;
            expected_out <= (state_nxt == FOURTH1);
            if (state_nxt == FOURTH1 && state != FOURTH1 && run_count != 8'hFF)
                run_count <= run_count + 8'd1;
        end
    end

endmodule

// File: rtl/accu_stim_tx.sv
// Serial transmitter for the one-accumulator: shifts a latched pattern out on
// bit_out with a level strobe per bit. Define ACCU_MODEL_EN to add the receiver model.
module accu_stim_tx #(
    parameter int PAT_W   = 16,
    parameter int STB_CYC = 2,
    parameter int GAP_CYC = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PAT_W-1:0]         pattern,
    input  logic [$clog2(PAT_W):0]   pat_len,
    input  logic                     loop,
    output logic                     bit_out,
    output logic                     strobe_out,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(PAT_W)-1:0] bit_idx,
    output logic                     expected_out,
    output logic [7:0]               run_count
);
    import accu_pkg::*;

    localparam int IDX_W = $clog2(PAT_W);
    localparam int LEN_W = IDX_W + 1;
    localparam int CNT_W = $clog2(max_int(STB_CYC, GAP_CYC));

    tx_state_t        state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q, len_eff;
    logic             done_q, done_nxt;
    logic             load;
    logic             last_bit;

    assign len_eff  = (pat_len == '0 || pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
    assign last_bit = ({1'b0, idx_q} == len_q - LEN_W'(1));

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        idx_nxt   = idx_q;
        done_nxt  = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                cnt_nxt   = '0;
                state_nxt = STROBE;
            end
            STROBE: begin
                if (cnt_q == CNT_W'(STB_CYC - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_nxt = '0;
                    if (!last_bit) begin
                        idx_nxt   = idx_q + IDX_W'(1);
                        state_nxt = SETUP;
                    end else if (loop) begin
                        idx_nxt   = '0;
                        state_nxt = SETUP;
                    end else begin
                        idx_nxt   = '0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the pattern register is a plain vector of flops, not a RAM, so it
    // is reset along with the rest of the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            idx_q   <= idx_nxt;
            done_q  <= done_nxt;
            if (load) begin
                pat_q <= pattern;
                len_q <= len_eff;
            end
        end
    end

    // Decoded straight from reset flops so a reset drops the strobe at once.
    assign bit_out    = (state_q != IDLE) && pat_q[idx_q];
    assign strobe_out = (state_q == STROBE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign bit_idx    = idx_q;

`ifdef ACCU_MODEL_EN
    logic       strobe_d;
    logic [2:0] model_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) strobe_d <= 1'b0;
        else       strobe_d <= strobe_out;
    end

    accu_ref_model u_model (
        .clk          (clk),
        .reset        (reset),
        .data_bit     (bit_out),
        .strobe_rise  (strobe_out & ~strobe_d),
        .state        (model_state),
        .expected_out (expected_out),
        .run_count    (run_count)
    );
`else
    assign expected_out = 1'b0;
    assign run_count    = 8'd0;
`endif

endmodule

// File: tb/tb_accu_stim_tx.sv
// Directed bench for accu_stim_tx with default parameters; model outputs are
// expected live only when ACCU_MODEL_EN is defined.
module tb_accu_stim_tx;

`ifdef ACCU_MODEL_EN
    localparam bit MODEL = 1'b1;
`else
    localparam bit MODEL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pattern = '0;
    logic [4:0]  pat_len = '0;
    logic        loop = 1'b0;
    logic        bit_out, strobe_out, busy, done, expected_out;
    logic [3:0]  bit_idx;
    logic [7:0]  run_count;

    int total = 0;
    int bad   = 0;

    int          cycles, strobes, hi, max_idx, done_cnt;
    logic [31:0] bits;

    accu_stim_tx dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pattern      (pattern),
        .pat_len      (pat_len),
        .loop         (loop),
        .bit_out      (bit_out),
        .strobe_out   (strobe_out),
        .busy         (busy),
        .done         (done),
        .bit_idx      (bit_idx),
        .expected_out (expected_out),
        .run_count    (run_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic start_tx(input logic [15:0] pat, input logic [4:0] len, input logic lp);
        pattern = pat;
        pat_len = len;
        loop    = lp;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_cycles(input int n, output int dcnt);
        dcnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dcnt++;
        end
    endtask

    task automatic run_to_done(input int budget, output int cyc, output int stb,
                               output int high, output logic [31:0] rx, output int mx);
        logic prev;
        prev = 1'b0; cyc = 0; stb = 0; high = 0; rx = '0; mx = 0;
        while (done !== 1'b1 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (strobe_out === 1'b1) high++;
            if (strobe_out === 1'b1 && !prev) begin
                if (stb < 32) rx[stb] = bit_out;
                stb++;
            end
            prev = strobe_out;
            if (int'(bit_idx) > mx) mx = int'(bit_idx);
        end
    endtask

    initial begin
        // Reset state, observed while reset is still asserted.
        #2;
        chk("rst_bit_out", bit_out, 0);
        chk("rst_strobe", strobe_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bit_idx", bit_idx, 0);
        chk("rst_expected_out", expected_out, 0);
        chk("rst_run_count", run_count, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Pass 1: four ones, first cycles checked step by step.
        start_tx(16'h000F, 5'd4, 1'b0);
        chk("t1_setup_busy", busy, 1);
        chk("t1_setup_strobe", strobe_out, 0);
        chk("t1_setup_bit", bit_out, 1);
        chk("t1_setup_idx", bit_idx, 0);
        @(posedge clk); #1;
        chk("t1_strobe_hi", strobe_out, 1);
        @(posedge clk); @(posedge clk); #1;
        chk("t1_gap_lo", strobe_out, 0);
        chk("t1_gap_bit", bit_out, 1);
        run_to_done(60, cycles, strobes, hi, bits, max_idx);
        chk("t1_done_cycle", cycles + 3, 24);
        chk("t1_done", done, 1);
        chk("t1_done_busy", busy, 0);
        chk("t1_done_bit_out", bit_out, 0);
        chk("t1_expected_out", expected_out, MODEL ? 1 : 0);
        chk("t1_run_count", run_count, MODEL ? 1 : 0);
        @(posedge clk); #1;
        chk("t1_done_pulse_len", done, 0);
        do_reset();

        // Pass 2: five ones then a zero.
        start_tx(16'h001F, 5'd6, 1'b0);
        run_to_done(80, cycles, strobes, hi, bits, max_idx);
        chk("t2_done_cycle", cycles, 36);
        chk("t2_strobes", strobes, 6);
        chk("t2_strobe_high", hi, 12);
        chk("t2_bits", bits, 32'h1F);
        chk("t2_max_idx", max_idx, 5);
        chk("t2_expected_out", expected_out, 0);
        chk("t2_run_count", run_count, MODEL ? 1 : 0);

        // Pass 3 starts in the done cycle; model continues from FIRST1.
        start_tx(16'h0055, 5'd7, 1'b0);
        chk("t3_accept_busy", busy, 1);
        chk("t3_accept_done", done, 0);
        run_to_done(80, cycles, strobes, hi, bits, max_idx);
        chk("t3_done_cycle", cycles, 42);
        chk("t3_bits", bits, 32'h55);
        chk("t3_max_idx", max_idx, 6);
        chk("t3_expected_out", expected_out, 0);
        chk("t3_run_count", run_count, MODEL ? 2 : 0);
        do_reset();

        // Looping: two full passes without done, then drop loop for a third.
        start_tx(16'h000F, 5'd4, 1'b1);
        run_cycles(48, done_cnt);
        chk("loop_no_done", done_cnt, 0);
        chk("loop_busy", busy, 1);
        chk("loop_idx_wrap", bit_idx, 0);
        chk("loop_run_count", run_count, MODEL ? 2 : 0);
        loop = 1'b0;
        run_to_done(60, cycles, strobes, hi, bits, max_idx);
        chk("loop_pass3_cycle", cycles, 24);
        chk("loop_pass3_bits", bits, 32'hF);
        chk("loop_run_count_end", run_count, MODEL ? 3 : 0);
        do_reset();

        // Reset during the strobe of bit 2.
        start_tx(16'h000F, 5'd4, 1'b0);
        run_cycles(13, done_cnt);
        chk("rmid_strobe", strobe_out, 1);
        chk("rmid_idx", bit_idx, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("rmid_strobe_drop", strobe_out, 0);
        chk("rmid_busy_drop", busy, 0);
        chk("rmid_bit_drop", bit_out, 0);
        chk("rmid_idx_clear", bit_idx, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_cycles(40, done_cnt);
        chk("rmid_no_done", done_cnt, 0);
        chk("rmid_run_count", run_count, 0);
        chk("rmid_expected_out", expected_out, 0);

        // pat_len=0 means 16 bits; a start while busy must be ignored.
        start_tx(16'hA5C3, 5'd0, 1'b0);
        pattern = 16'hFFFF;
        pat_len = 5'd3;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        chk("busy_start_bit", bit_out, 1);
        chk("busy_start_idx", bit_idx, 0);
        run_to_done(200, cycles, strobes, hi, bits, max_idx);
        chk("full_done_cycle", cycles + 1, 96);
        chk("full_strobes", strobes, 16);
        chk("full_bits", bits, 32'hA5C3);
        chk("full_max_idx", max_idx, 15);
        chk("full_expected_out", expected_out, MODEL ? 1 : 0);
        chk("full_run_count", run_count, MODEL ? 2 : 0);
        @(posedge clk); #1;
        chk("full_idle_after", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
